apb_cmd_requester: RTL and testbench

APB_CMD_REQUESTER -- requirements
Module: apb_cmd_requester

---
 rtl/apb_cmd_requester.sv | 128 ++++++++++++
 tb/tb_apb_cmd_requester.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_requester.sv
// Single-outstanding bridge from a valid/ready command stream to an APB requester port.
// Each command runs one APB transfer and returns exactly one response, optionally bounded by a timeout.
module apb_cmd_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 accept, done, timeout_hit;
  logic                 psel_d, penable_d, cmd_ready_d, rsp_valid_d;

  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  assign done        = (state == ACCESS) && pready;
  assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !pready && (wait_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on preset_n.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (done || timeout_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are decoded from the upcoming state and registered, so none is combinational.
  always_comb begin
    psel_d      = (next_state == SETUP) || (next_state == ACCESS);
    penable_d   = (next_state == ACCESS);
    cmd_ready_d = (next_state == IDLE);
    rsp_valid_d = (next_state == RESP);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      psel      <= psel_d;
      penable   <= penable_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // Transfer attributes are captured once at acceptance and held until the next command.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      paddr  <= '0;
      pprot  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      paddr  <= cmd_addr;
      pprot  <= cmd_prot;
      pwrite <= cmd_write;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb : '0;
    end
  end

  // Counts ACCESS cycles spent with pready low; restarts for every transfer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                           wait_cnt <= '0;
    else if (state != ACCESS || timeout_hit) wait_cnt <= '0;
    else if (!pready)                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (done) begin
      rsp_rdata   <= pwrite ? '0 : prdata;
      rsp_err     <= pslverr;
      rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Randomized bench for apb_cmd_requester: a planned APB completer plus a response scoreboard.
// The stimulus process plans each transfer; completer and response monitor check independently.
module tb_apb_cmd_requester;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          n_wait;
    logic [31:0] rdata;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  logic          pclk;
  logic          preset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int    n_checks = 0;
  int    n_fail   = 0;
  plan_t plan_q[$];
  rsp_t  exp_q[$];

  apb_cmd_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  logic [109:0] all_out;
  assign all_out = {psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                    rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready};

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response derived from the planned completer behaviour.
  function automatic rsp_t model(input plan_t p);
    rsp_t r;
    if (p.n_wait >= TIMEOUT) begin
      r.rdata = '0; r.err = 1'b1; r.timeout = 1'b1;
    end else begin
      r.rdata = p.write ? 32'h0 : p.rdata; r.err = p.err; r.timeout = 1'b0;
    end
    return r;
  endfunction

  // Completer: serves transfers from plan_q and checks the requester side of APB.
  plan_t cur;
  bit    active = 0;
  int    acc = 0;
  always @(negedge pclk) begin
    if (!preset_n) begin
      active = 0;
      pready = 1'b0;
    end else begin
      if (psel && !penable) begin
        check("plan_available", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          active = 1;
          acc = 0;
          check("setup_fields", {paddr, pwrite, pwdata, pstrb, pprot},
                {cur.addr, cur.write, cur.write ? cur.wdata : 32'h0, cur.write ? cur.strb : 4'h0, cur.prot});
        end
      end else if (psel && penable && active) begin
        acc++;
        check("access_fields", {paddr, pwrite, pwdata, pstrb, pprot},
              {cur.addr, cur.write, cur.write ? cur.wdata : 32'h0, cur.write ? cur.strb : 4'h0, cur.prot});
      end else if (!psel && active) begin
        check("access_cycles", acc, (cur.n_wait >= TIMEOUT) ? TIMEOUT : cur.n_wait + 1);
        active = 0;
      end
      if (psel && penable && active && acc > cur.n_wait) begin
        pready  = 1'b1;
        prdata  = cur.rdata;
        pslverr = cur.err;
      end else if (psel && penable && active) begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = ~cur.err;
      end else begin
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and checks it stays stable.
  rsp_t         mon_exp;
  logic [33:0]  held;
  bit           holding = 0;
  int           hold_left = 0;
  always @(negedge pclk) begin
    if (!preset_n) begin
      holding = 0;
      rsp_ready = 1'b0;
    end else if (rsp_valid) begin
      check("no_cmd_ready_with_rsp", cmd_ready, 0);
      if (!holding) begin
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("rsp", {rsp_rdata, rsp_err, rsp_timeout}, {mon_exp.rdata, mon_exp.err, mon_exp.timeout});
          held = {rsp_rdata, rsp_err, rsp_timeout};
          holding = 1;
          hold_left = $urandom_range(0, 5);
        end
      end else begin
        check("rsp_stable", {rsp_rdata, rsp_err, rsp_timeout}, held);
      end
      if (holding && hold_left == 0) begin
        rsp_ready = 1'b1;
        holding = 0;
      end else begin
        rsp_ready = 1'b0;
        if (hold_left > 0) hold_left--;
      end
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Presents one command, waits for acceptance, then records the plan and the expected response.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int n_wait,
                       input logic [31:0] rdata, input logic err, input bit expect_rsp);
    plan_t p;
    int    tries = 0;
    p.write = wr; p.addr = addr; p.wdata = wdata; p.strb = strb; p.prot = prot;
    p.n_wait = n_wait; p.rdata = rdata; p.err = err;
    cmd_valid = 1'b1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    while (!cmd_ready && tries < 200) begin
      @(negedge pclk);
      tries++;
    end
    check("cmd_accepted_in_time", tries < 200, 1);
    plan_q.push_back(p);
    if (expect_rsp) exp_q.push_back(model(p));
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    cmd_addr  = $urandom;
  endtask

  task automatic drain();
    int tries = 0;
    while ((exp_q.size() != 0 || rsp_valid || psel) && tries < 500) begin
      @(negedge pclk);
      tries++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int r, n_wait, tries;
    @(negedge pclk);
    check("reset_outputs", all_out, 0);
    @(negedge pclk);
    check("reset_outputs_held", all_out, 0);
    #2 preset_n = 1'b1;
    @(negedge pclk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    issue(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'd2, 3, 32'hDEAD_BEEF, 1'b0, 1);
    issue(1'b1, 32'h30, 32'h0BAD_F00D, 4'h3, 3'd5, 2, 32'h0, 1'b1, 1);
    issue(1'b0, 32'h40, 32'h0, 4'hF, 3'd1, TIMEOUT, 32'hCAFE_F00D, 1'b0, 1);
    issue(1'b0, 32'h44, 32'h0, 4'h0, 3'd7, TIMEOUT - 1, 32'h1357_9BDF, 1'b0, 1);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      n_wait = $urandom_range(0, 3);
      else if (r == 6) n_wait = TIMEOUT - 1;
      else if (r == 7) n_wait = TIMEOUT;
      else if (r == 8) n_wait = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
      else             n_wait = $urandom_range(4, TIMEOUT - 2);
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom),
            n_wait, $urandom, 1'($urandom_range(0, 3) == 0), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge pclk);
    end
    drain();

    // Reset pulse in the middle of an ACCESS phase: no response may follow.
    issue(1'b1, 32'h44, 32'h5A5A_C3C3, 4'hF, 3'd3, 40, 32'h0, 1'b0, 0);
    tries = 0;
    do begin
      @(negedge pclk);
      tries++;
    end while (!(psel && penable) && tries < 50);
    check("reached_access", psel && penable, 1);
    #2 preset_n = 1'b0;
    #1 check("async_reset_outputs", all_out, 0);
    @(negedge pclk);
    #2 preset_n = 1'b1;
    @(negedge pclk);
    check("cmd_ready_after_midreset", {cmd_ready, rsp_valid, psel}, 3'b100);

    issue(1'b0, 32'h50, 32'h0, 4'hF, 3'd0, 1, 32'h600D_D00D, 1'b0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
